syncfifo_lvl: RTL and testbench
===============================

Name: syncfifo_lvl

Overview:
Single-clock, parametrised successor to the dual-clock FIFO, for paths where producer and consumer share one clock domain, e.g. controller-to-AES-core data staging. It adds:
- a registered read port with an explicit rdv strobe;
- a fill-level output;
- programmable almost-full and almost-empty flags;
- a synchronous flush.
Gray-code pointer synchronisation is not needed; binary pointers are used.

Parameters:
AWIDTH, 5, address width; depth DEPTH = 2**AWIDTH entries.
DWIDTH, 32, data word width.
AF_THRESH, 28, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  synchronous clear of FIFO contents and pointers.
wdv  input  1  write request; data accepted when wdv & ~wfull.
wdata  input  DWIDTH  write data.
wfull  output  1  count == DEPTH.
rrq  input  1  read request; accepted when rrq & ~rempty.
rdata  output  DWIDTH  registered read data.
rdv  output  1  rdata valid; one-cycle pulse per accepted read.
rempty  output  1  count == 0.
almost_full  output  1  count >= AF_THRESH.
almost_empty  output  1  count <= AE_THRESH.
count  output  AWIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset: clk is the only clock. rst is synchronous, active-high and sampled on the rising edge. On reset:
  - wptr, rptr and count are 0; rdata is 0; rdv is 0;
  - rempty=1, wfull=0, almost_empty=1, almost_full=0.
  - RAM contents are not cleared.
- Pointers: wptr and rptr are AWIDTH+1 bits, binary, wrapping modulo 2*DEPTH. The RAM is addressed by the low AWIDTH bits.
- Write/read enables: wen = wdv & ~wfull; ren = rrq & ~rempty, both evaluated on the current-cycle flags.
- Write: wen writes wdata at wptr[AWIDTH-1:0]; wptr increments.
- Read latency is 1 cycle. ren in cycle N gives rdata = mem[rptr] and rdv=1 in cycle N+1; rptr increments.
- rdata holds its last value when no read occurs. rdv is 0 in every cycle not following an accepted read.
- count update: +1 on wen only, -1 on ren only, unchanged on both or neither. All flags are pure functions of the registered count.
- Full with wdv & rrq: the read is accepted, the write is refused; count goes DEPTH -> DEPTH-1.
- Empty with wdv & rrq: the write is accepted, the read is refused (no rdv); rempty drops the next cycle.
- Write while full: silently dropped; state unchanged.
- Read while empty: ignored; rdv stays 0.
- Flush (priority rst > flush > wen/ren):
  - pointers and count go to 0, rdv=0 next cycle, rdata is held;
  - any wen/ren in the flush cycle is discarded.
- Reset or flush mid-burst: any rdv due from the prior cycle is suppressed. Stale RAM contents are unreachable.
- Wrap-around: the pointer MSB toggles each pass; ordering is preserved across any number of passes.

Optional Feature:
Macro SYNCFIFO_ERR_STICKY_EN.
- Defined: adds outputs ovf and udf (1 bit each, reset 0).
  - ovf sets on wdv & wfull; udf sets on rrq & rempty.
  - Both are sticky until rst or flush.
  - A flush in the same cycle as the error clears the flag (flush wins).
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package syncfifo_pkg: DEPTH derivation function, pointer/count width constants, and parameter legality checks (elaboration-time assertion on threshold ranges).
- One sub-module, sfifo_ram: single-clock simple dual-port RAM with a registered read port (we, waddr, wdata, re, raddr, rdata). It holds storage only, with no reset on the array.
- Pointers, count, flags and rdv live in the top level.

Test Plan:
- Reset then idle → count=0, rempty=1, almost_empty=1, wfull=0, rdv=0, rdata=0.
- Write 32 words 0x1..0x20 (AWIDTH=5) → count=32, wfull=1, almost_full asserted from the 28th write. A 33rd write of 0xDEAD is dropped (ovf=1 with macro). Reading 32 words returns 0x1..0x20 in order, each with rdv one cycle after rrq.
- Fill to 32, then assert wdv & rrq for one cycle → one read accepted, write refused, count=31. Empty state with wdv & rrq → count=1, no rdv.
- Continuous simultaneous write/read for 100 cycles at count=10 (pointers wrap ≥3 times) → count stays 10, data order intact, no flag changes.
- Write 5 words, assert flush in the same cycle as rrq → next cycle count=0, rempty=1, rdv=0. A subsequent write of 0xA5 reads back 0xA5.
- rrq on empty FIFO → rdv stays 0, count stays 0 (udf=1 with macro). rst mid-read: rdv is 0 the following cycle.

Source files
------------

// File: rtl/syncfifo_pkg.sv
// Shared constants and helpers for the single-clock level-reporting FIFO.
// Optional sticky error flags are enabled by defining SYNCFIFO_ERR_STICKY_EN.
package syncfifo_pkg;

   localparam int AWIDTH_DEF    = 5;
   localparam int DWIDTH_DEF    = 32;
   localparam int AF_THRESH_DEF = 28;
   localparam int AE_THRESH_DEF = 4;

   function automatic int depth_f(input int aw);
      return 1 << aw;
   endfunction

   // Pointers and count share one width: one extra bit beyond the RAM address.
   function automatic int ptr_w_f(input int aw);
      return aw + 1;
   endfunction

   function automatic bit thresh_ok(input int aw, input int af, input int ae);
      return (af >= 1) && (af <= depth_f(aw)) && (ae >= 0) && (ae <= depth_f(aw) - 1);
   endfunction

endpackage

// File: rtl/sfifo_ram.sv
// Simple dual-port RAM with a registered read port; storage array is never reset.
module sfifo_ram #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AWIDTH-1:0] waddr,
   input  logic [DWIDTH-1:0] wdata,
   input  logic              re,
   input  logic [AWIDTH-1:0] raddr,
   output logic [DWIDTH-1:0] rdata
);

   logic [DWIDTH-1:0] r_mem [2**AWIDTH];
   logic [DWIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   // Only the output register is cleared; it holds whenever no read is issued.
   always_ff @(posedge clk) begin
      if (rst)     r_rdata <= '0;
      else if (re) r_rdata <= r_mem[raddr];
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/syncfifo_lvl.sv
// Single-clock FIFO with fill level, almost flags, flush and registered read port.
// Define SYNCFIFO_ERR_STICKY_EN to add sticky ovf/udf error outputs.
module syncfifo_lvl
   import syncfifo_pkg::*;
#(
   parameter int AWIDTH    = AWIDTH_DEF,
   parameter int DWIDTH    = DWIDTH_DEF,
   parameter int AF_THRESH = AF_THRESH_DEF,
   parameter int AE_THRESH = AE_THRESH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wdv,
   input  logic [DWIDTH-1:0] wdata,
   output logic              wfull,
   input  logic              rrq,
   output logic [DWIDTH-1:0] rdata,
   output logic              rdv,
   output logic              rempty,
   output logic              almost_full,
   output logic              almost_empty,
`ifdef SYNCFIFO_ERR_STICKY_EN
   output logic              ovf,
   output logic              udf,
`endif
   output logic [AWIDTH:0]   count
);

   localparam int            PW      = ptr_w_f(AWIDTH);
   localparam logic [PW-1:0] C_DEPTH = PW'(depth_f(AWIDTH));
   localparam logic [PW-1:0] C_AF    = PW'(AF_THRESH);
   localparam logic [PW-1:0] C_AE    = PW'(AE_THRESH);
   localparam logic [PW-1:0] C_ONE   = PW'(1);

   if (!thresh_ok(AWIDTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
      $error("syncfifo_lvl: AF_THRESH/AE_THRESH out of range for AWIDTH");
   end

   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW-1:0] r_count;
   logic          r_rdv;
   logic          w_wen;
   logic          w_ren;

   // Flush and reset discard any request issued in the same cycle.
   assign w_wen = wdv & ~wfull  & ~flush & ~rst;
   assign w_ren = rrq & ~rempty & ~flush & ~rst;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_rdv   <= 1'b0;
      end else begin
         if (w_wen) r_wptr <= r_wptr + C_ONE;
         if (w_ren) r_rptr <= r_rptr + C_ONE;
         case ({w_wen, w_ren})
            2'b10:   r_count <= r_count + C_ONE;
            2'b01:   r_count <= r_count - C_ONE;
            default: r_count <= r_count;
         endcase
         r_rdv <= w_ren;
      end
   end

   sfifo_ram #(
      .AWIDTH (AWIDTH),
      .DWIDTH (DWIDTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (w_wen),
      .waddr (r_wptr[AWIDTH-1:0]),
      .wdata (wdata),
      .re    (w_ren),
      .raddr (r_rptr[AWIDTH-1:0]),
      .rdata (rdata)
   );

   assign count        = r_count;
   assign rdv          = r_rdv;
   assign rempty       = (r_count == '0);
   assign wfull        = (r_count == C_DEPTH);
   assign almost_full  = (r_count >= C_AF);
   assign almost_empty = (r_count <= C_AE);

`ifdef SYNCFIFO_ERR_STICKY_EN
   logic r_ovf;
   logic r_udf;

   // Clearing wins over a same-cycle error.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (wdv & wfull)  r_ovf <= 1'b1;
         if (rrq & rempty) r_udf <= 1'b1;
      end
   end

   assign ovf = r_ovf;
   assign udf = r_udf;
`endif

endmodule

// File: tb/tb_syncfifo_lvl.sv
// Directed plus randomized bench for syncfifo_lvl against a queue-based reference model.
// Honours SYNCFIFO_ERR_STICKY_EN for the sticky error outputs.
module tb_syncfifo_lvl;
   import syncfifo_pkg::*;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int AF    = 28;
   localparam int AE    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          wdv = 1'b0;
   logic          rrq = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic          wfull, rdv, rempty, almost_full, almost_empty;
   logic [DW-1:0] rdata;
   logic [AW:0]   count;
`ifdef SYNCFIFO_ERR_STICKY_EN
   logic          ovf, udf;
`endif

   syncfifo_lvl #(
      .AWIDTH(AW), .DWIDTH(DW), .AF_THRESH(AF), .AE_THRESH(AE)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .wdv(wdv), .wdata(wdata),
      .wfull(wfull), .rrq(rrq), .rdata(rdata), .rdv(rdv), .rempty(rempty),
      .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef SYNCFIFO_ERR_STICKY_EN
      .ovf(ovf), .udf(udf),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   int            nchk = 0;
   int            nerr = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_rdata = '0;
   bit            m_rdv   = 1'b0;
   bit            m_ovf   = 1'b0;
   bit            m_udf   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, then sample outputs after the edge.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit f, input bit rs, input string tag);
      bit full, empty;
      rst = rs; flush = f; wdv = w; wdata = d; rrq = r;
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (rs) begin
         q.delete(); m_rdv = 0; m_rdata = '0; m_ovf = 0; m_udf = 0;
      end else if (f) begin
         q.delete(); m_rdv = 0; m_ovf = 0; m_udf = 0;
      end else begin
         m_rdv = r && !empty;
         if (m_rdv) m_rdata = q.pop_front();
         if (w && !full) q.push_back(d);
         if (w && full)  m_ovf = 1;
         if (r && empty) m_udf = 1;
      end
      @(posedge clk); #1;
      chk({tag, ".count"},  32'(count),        32'(q.size()));
      chk({tag, ".rempty"}, 32'(rempty),       32'(q.size() == 0));
      chk({tag, ".wfull"},  32'(wfull),        32'(q.size() == DEPTH));
      chk({tag, ".afull"},  32'(almost_full),  32'(q.size() >= AF));
      chk({tag, ".aempty"}, 32'(almost_empty), 32'(q.size() <= AE));
      chk({tag, ".rdv"},    32'(rdv),          32'(m_rdv));
      chk({tag, ".rdata"},  rdata,             m_rdata);
`ifdef SYNCFIFO_ERR_STICKY_EN
      chk({tag, ".ovf"},    32'(ovf),          32'(m_ovf));
      chk({tag, ".udf"},    32'(udf),          32'(m_udf));
`endif
   endtask

   initial begin
      bit w, r, f;
      int wp, rp;

      // Reset and idle
      step(0, '0, 0, 0, 1, "rst0");
      step(0, '0, 0, 0, 1, "rst1");
      step(0, '0, 0, 0, 0, "idle");
      chk("idle.count_zero", 32'(count), 32'd0);

      // Fill with 1..32, overflow attempt, drain in order
      for (int i = 1; i <= DEPTH; i++) step(1, DW'(i), 0, 0, 0, "fill");
      chk("fill.full_flag", 32'(wfull), 32'd1);
      step(1, 32'hDEAD, 0, 0, 0, "ovfwr");
      for (int i = 1; i <= DEPTH; i++) begin
         step(0, '0, 1, 0, 0, "drain");
         chk("drain.order", rdata, DW'(i));
      end
      step(0, '0, 0, 0, 0, "drain_idle");

      // Full with simultaneous write/read, then empty with both
      for (int i = 0; i < DEPTH; i++) step(1, $urandom, 0, 0, 0, "refill");
      step(1, 32'hBEEF, 1, 0, 0, "full_wr");
      chk("full_wr.count31", 32'(count), 32'd31);
      for (int i = 0; i < 31; i++) step(0, '0, 1, 0, 0, "drain2");
      step(0, '0, 0, 0, 0, "drain2_idle");
      step(1, 32'h1234_5678, 1, 0, 0, "empty_wr");
      chk("empty_wr.norv", 32'(rdv), 32'd0);
      step(0, '0, 1, 0, 0, "empty_rd");
      step(0, '0, 0, 0, 0, "empty_idle");

      // Steady streaming at level 10 across several pointer wraps
      for (int i = 0; i < 10; i++) step(1, $urandom, 0, 0, 0, "pre10");
      for (int i = 0; i < 100; i++) step(1, $urandom, 1, 0, 0, "stream");
      chk("stream.level", 32'(count), 32'd10);
      for (int i = 0; i < 10; i++) step(0, '0, 1, 0, 0, "post10");

      // Flush concurrent with a read request
      for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0, 0, "pref");
      step(0, '0, 1, 1, 0, "flush");
      chk("flush.rdv", 32'(rdv), 32'd0);
      step(1, 32'hA5, 0, 0, 0, "post_flush_wr");
      step(0, '0, 1, 0, 0, "post_flush_rd");
      chk("post_flush.a5", rdata, 32'hA5);

      // Underflow, then reset during a read
      step(0, '0, 1, 0, 0, "udf_rd");
      step(0, '0, 0, 0, 0, "udf_idle");
      for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0, 0, "prerst");
      step(0, '0, 1, 0, 0, "rd_before_rst");
      step(0, '0, 1, 0, 1, "rst_mid");
      chk("rst_mid.rdv", 32'(rdv), 32'd0);
      step(0, '0, 0, 0, 0, "rst_idle");

      // Randomized traffic with alternating bias and occasional flush
      for (int seg = 0; seg < 8; seg++) begin
         wp = (seg % 2 == 0) ? 80 : 30;
         rp = (seg % 2 == 0) ? 30 : 80;
         for (int i = 0; i < 50; i++) begin
            w = ($urandom_range(0, 99) < wp);
            r = ($urandom_range(0, 99) < rp);
            f = ($urandom_range(0, 63) == 0);
            step(w, $urandom, r, f, 0, "rand");
         end
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
